rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares one output channel between `N_REQ` requesters. It selects one requester through an internal N:1 data multiplexer and registers that requester's data into a single output stage. Both sides use valid/ready handshakes. The block sits in front of any single-consumer resource: a shared bus, a FIFO write port or a downstream datapath stage.

---
 rtl/rr_mux_arbiter.sv | 84 ++++++++
 tb/tb_rr_mux_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter feeding a single registered output stage through an N:1 data mux.
// Both sides use valid/ready; the grant is combinational, data/id are registered.
module rr_mux_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic [IDW-1:0]         out_id,
   input  logic                   out_ready
);

   logic [IDW-1:0]   r_ptr;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [IDW-1:0]   r_out_id;

   logic [WIDTH-1:0] w_slice    [N_REQ];
   logic [IDW-1:0]   w_cand_idx [N_REQ];
   logic [N_REQ-1:0] w_cand_hit;
   logic             w_any;
   logic [IDW-1:0]   w_winner;
   logic             w_load_en;
   logic             w_take;
   logic [IDW-1:0]   w_next_ptr;
   logic [WIDTH-1:0] w_win_data;

   // Candidate k is requester (ptr + k) mod N_REQ; works for non power-of-two N_REQ.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDW:0] w_sum;
      assign w_slice[gi]    = req_data[gi*WIDTH +: WIDTH];
      assign w_sum          = {1'b0, r_ptr} + (IDW+1)'(gi);
      assign w_cand_idx[gi] = (w_sum >= (IDW+1)'(N_REQ)) ?
                              IDW'(w_sum - (IDW+1)'(N_REQ)) : w_sum[IDW-1:0];
      assign w_cand_hit[gi] = req_valid[w_cand_idx[gi]];
   end

   always_comb begin
      w_any    = 1'b0;
      w_winner = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_cand_hit[k]) begin
            w_any    = 1'b1;
            w_winner = w_cand_idx[k];
         end
      end
   end

   assign w_load_en  = !r_out_valid || out_ready;
   assign w_take     = w_load_en && w_any && !rst;
   assign w_next_ptr = (w_winner == IDW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
   assign w_win_data = w_slice[w_winner];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = w_take && (w_winner == IDW'(gi));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_id    <= '0;
      end else if (w_take) begin
         r_ptr       <= w_next_ptr;
         r_out_valid <= 1'b1;
         r_out_data  <= w_win_data;
         r_out_id    <= w_winner;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_id    = r_out_id;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a driver predicts grants and queues expected
// items, a negedge monitor pops and compares whenever the output is accepted.
module tb_rr_mux_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_id;
   logic           out_ready = 1'b0;

   rr_mux_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
      .out_id(out_id), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit running  = 1'b1;

   // Reference state: priority pointer, requests still waiting, expected item queue.
   int           m_ptr = 0;
   logic [N-1:0] held = '0;
   logic [W-1:0] cur_data   [N];
   logic [W-1:0] fixed_data [N];
   logic [W-1:0] exp_d [$];
   int           exp_id [$];
   bit           pend_v = 1'b0;
   logic [W-1:0] pend_d;
   int           pend_id;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus; g returns the predicted grant (-1 for none).
   task automatic cycle(input logic [N-1:0] newv, input logic ordy, input bit rnd, output int g);
      logic [N-1:0] rv;
      logic [N-1:0] exp_ready;
      @(posedge clk);
      if (pend_v) begin
         exp_d.push_back(pend_d);
         exp_id.push_back(pend_id);
         pend_v = 1'b0;
      end
      #1;
      for (int i = 0; i < N; i++)
         if (!held[i] && newv[i]) cur_data[i] = rnd ? W'($urandom) : fixed_data[i];
      rv = held | newv;
      req_valid = rv;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = cur_data[i];
      out_ready = ordy;
      #1;
      g = -1;
      if (exp_d.size() == 0 || ordy) begin
         for (int k = N - 1; k >= 0; k--)
            if (rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (g >= 0) begin
         pend_v  = 1'b1;
         pend_d  = cur_data[g];
         pend_id = g;
         m_ptr   = (g + 1) % N;
      end
      held = rv & ~exp_ready;
      $display("cyc t=%0t req_valid=%b out_ready=%b grant=%0d", $time, rv, ordy, g);
   endtask

   task automatic do_reset(input int n, input logic [N-1:0] rv);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         rst = 1'b1;
         req_valid = rv;
         exp_d.delete();
         exp_id.delete();
         pend_v = 1'b0;
         held = '0;
         m_ptr = 0;
         #1;
         chk("req_ready_in_reset", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid = '0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);
      $display("reset t=%0t cycles=%0d", $time, n);
   endtask

   // Monitor: output must be valid exactly when an item is outstanding; compare on accept.
   initial begin
      forever begin
         @(negedge clk);
         if (running && !rst) begin
            chk("out_valid", 32'(out_valid), 32'(exp_d.size() != 0));
            if (out_valid && out_ready && exp_d.size() != 0) begin
               logic [W-1:0] ed;
               int           ei;
               ed = exp_d.pop_front();
               ei = exp_id.pop_front();
               chk("out_data", 32'(out_data), 32'(ed));
               chk("out_id", 32'(out_id), 32'(ei));
               $display("out t=%0t id=%0d data=%02h", $time, out_id, out_data);
            end
         end
      end
   end

   initial begin
      int g;
      for (int i = 0; i < N; i++) begin
         fixed_data[i] = W'(8'h10 + i);
         cur_data[i]   = '0;
      end

      // Reset with all requesters asking
      do_reset(2, 4'b1111);

      // Single request from requester 2
      fixed_data[2] = 8'hA5;
      cycle(4'b0100, 1'b1, 1'b0, g);
      chk("single_grant", 32'(g), 32'd2);
      cycle(4'b0000, 1'b1, 1'b0, g);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'hA5);
      chk("single_id", 32'(out_id), 32'd2);
      cycle(4'b1111, 1'b1, 1'b0, g);
      chk("ptr_after_single", 32'(g), 32'd3);
      fixed_data[2] = 8'h12;
      for (int c = 0; c < 5; c++) cycle(4'b0000, 1'b1, 1'b0, g);

      // Round-robin fairness from reset, with a mid-stream reset
      do_reset(1, 4'b0000);
      for (int c = 0; c < 6; c++) begin
         cycle(4'b1111, 1'b1, 1'b0, g);
         chk("rr_grant", 32'(g), 32'(c % N));
      end
      do_reset(1, 4'b1111);
      cycle(4'b1111, 1'b1, 1'b0, g);
      chk("grant_after_midreset", 32'(g), 32'd0);

      // Stall while holding id 1, then release
      cycle(4'b1111, 1'b1, 1'b0, g);
      chk("stall_setup_grant", 32'(g), 32'd1);
      for (int c = 0; c < 3; c++) begin
         cycle(4'b0000, 1'b0, 1'b0, g);
         chk("stall_no_grant", 32'(g), 32'hFFFF_FFFF);
         chk("stall_id_hold", 32'(out_id), 32'd1);
         chk("stall_data_hold", 32'(out_data), 32'h11);
      end
      cycle(4'b0000, 1'b1, 1'b0, g);
      chk("release_grant", 32'(g), 32'd2);
      for (int c = 0; c < 4; c++) cycle(4'b0000, 1'b1, 1'b0, g);

      // Pointer wrap and skip
      do_reset(1, 4'b0000);
      cycle(4'b0100, 1'b1, 1'b0, g);
      chk("wrap_setup", 32'(g), 32'd2);
      cycle(4'b0011, 1'b1, 1'b0, g);
      chk("wrap_first", 32'(g), 32'd0);
      cycle(4'b0000, 1'b1, 1'b0, g);
      chk("wrap_second", 32'(g), 32'd1);
      cycle(4'b0000, 1'b1, 1'b0, g);

      // Randomized traffic with occasional resets
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 99) == 0) do_reset(1, N'($urandom));
         cycle(N'($urandom), ($urandom_range(0, 3) != 0), 1'b1, g);
      end
      for (int c = 0; c < 8; c++) cycle(4'b0000, 1'b1, 1'b0, g);

      @(posedge clk);
      #1;
      chk("drain_empty", 32'(exp_d.size()), 32'd0);
      running = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
